cpu_mem_arbiter: RTL
====================

# cpu_mem_arbiter

Parametrised memory-side bridge between the CPU core's sram-like request channels and a single sram-like memory port. Each channel's virtual address is translated through the fixed kseg mapping. Channels are arbitrated round-robin, and up to DEPTH accepted requests may be outstanding; an in-order ID FIFO routes each returning response to the channel that issued it. It sits between mycpu_core and the bus/memory interface in the top level and replaces the per-channel combinational translators.

## Interface
- NCH, 2, number of request channels; channel 0 is instruction fetch, channel 1 is data.
- DEPTH, 4, maximum outstanding accepted requests; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- XLATE, 1, enables kseg translation; 0 passes addresses through unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- ch_req  in  NCH  per-channel request; held stable with its fields until ch_addr_ok
- ch_wr  in  NCH  1 = write, 0 = read
- ch_size  in  2*NCH  0 = byte, 1 = half, 2 = word; channel i at [2i+1:2i]
- ch_addr  in  ADDR_W*NCH  virtual address, channel i slice
- ch_wdata  in  DATA_W*NCH  write data, channel i slice
- ch_addr_ok  out  NCH  request of channel i accepted this cycle
- ch_data_ok  out  NCH  response for channel i completes this cycle
- ch_rdata  out  DATA_W  read data broadcast to all channels; qualified by ch_data_ok
- mem_req, mem_wr  out  1  memory request and direction
- mem_size  out  2  memory access size
- mem_addr  out  ADDR_W  physical address
- mem_wdata  out  DATA_W  memory write data
- mem_addr_ok  in  1  memory accepts the request
- mem_data_ok  in  1  memory returns a response, in order
- mem_rdata  in  DATA_W  memory read data
- err  out  1  sticky flag: mem_data_ok arrived with no outstanding request

## Operation
- Translation (XLATE=1):
  - addresses in 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) have bits [31:29] cleared;
  - all other addresses pass through unchanged;
  - the mapping is purely combinational on the granted channel's address.
- States:
  - IDLE: no grant is held.
  - HOLD: grant is locked to channel gnt.
- IDLE:
  - If any ch_req is high and count < DEPTH, the winner is the first requesting channel at or after rr_ptr, wrapping modulo NCH.
  - The winner's fields drive the mem_* outputs and mem_req=1.
  - If mem_addr_ok is high in the same cycle, the request is accepted. Otherwise the next state is HOLD with gnt = winner.
- HOLD:
  - The mem_* outputs are driven from channel gnt. Lower-priority arrivals cannot steal the grant.
  - Acceptance returns the block to IDLE.
- Acceptance (mem_req && mem_addr_ok):
  - ch_addr_ok[winner]=1 combinationally;
  - winner ID is pushed into the FIFO;
  - rr_ptr = (winner+1) mod NCH.
- Full: when count == DEPTH, mem_req=0, even if mem_data_ok is high in the same cycle. HOLD is kept across full.
- Response (mem_data_ok with count > 0):
  - pop the FIFO head h;
  - ch_data_ok[h]=1 and ch_rdata = mem_rdata, both combinational;
  - no other channel sees data_ok.
- mem_data_ok with count == 0: ignored and err set to 1. err stays 1 until reset.
- Push and pop in the same cycle: count unchanged; FIFO pointers wrap modulo DEPTH.
- Memory contract: mem_data_ok for a request is never earlier than the cycle after its mem_addr_ok.

## Timing
- Zero-cycle paths: ch_req → mem_req; mem_addr_ok → ch_addr_ok; mem_data_ok → ch_data_ok.
- Minimum read latency is 1 cycle after acceptance, set by the memory.
- Throughput is one acceptance per cycle while not full.
- While resetn is low, and after its release until the first request:
  - mem_req=0, all ch_addr_ok=0, ch_data_ok=0, err=0;
  - state=IDLE, rr_ptr=0, count=0, FIFO pointers=0.
- Reset mid-transaction discards all outstanding IDs. The memory must be reset together with this block.
- ch_rdata equals mem_rdata at all times.

## Test plan
- Translation: channel 0 reads 0xBFC0_0000 with mem_addr_ok tied 1 → mem_addr=0x1FC0_0000 and ch_addr_ok=2'b01; channel 1 at 0x0000_1000 → mem_addr=0x0000_1000.
- Round-robin: both channels request continuously with mem_addr_ok=1 → grants alternate 0,1,0,1 starting with channel 0 after reset.
- Hold: channel 1 granted and mem_addr_ok low for 3 cycles while channel 0 also requests → mem_addr stays on channel 1 all 3 cycles; channel 1 is accepted on cycle 4, then channel 0.
- Ordering/full (DEPTH=4): accept IDs 0,1,0,1 with no mem_data_ok → 5th cycle mem_req=0; then four mem_data_ok pulses yield ch_data_ok 01,10,01,10 with ch_rdata matching the sequence 0xA,0xB,0xC,0xD.
- Simultaneous: count=2, push and pop in the same cycle → count stays 2 and the next pop routes to the correct ID.
- Error/reset: mem_data_ok with count=0 → err=1 and no ch_data_ok; then pulse resetn low mid-HOLD → err=0, mem_req=0, state IDLE, and the next grant goes to channel 0.

Source files
------------

// File: rtl/cpu_mem_arbiter_if.sv
// CPU request channels and single memory port bundled for the memory-side arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU/memory environment's view.
interface cpu_mem_arbiter_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_wr;
    logic [2*NCH-1:0]      ch_size;
    logic [ADDR_W*NCH-1:0] ch_addr;
    logic [DATA_W*NCH-1:0] ch_wdata;
    logic [NCH-1:0]        ch_addr_ok;
    logic [NCH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]     ch_rdata;

    logic                  mem_req;
    logic                  mem_wr;
    logic [1:0]            mem_size;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  err;

    modport slave (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata, err
    );

    modport master (
        output ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter from NCH CPU request channels onto one sram-like memory port,
// with kseg0/kseg1 translation and an in-order ID FIFO routing responses back.
module cpu_mem_arbiter #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned XLATE  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    cpu_mem_arbiter_if.slave  bus
);
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CH_W-1:0]   fifo_q [DEPTH];
    logic [CH_W-1:0]   fifo_d [DEPTH];
    logic              err_q, err_d;

    logic [CH_W-1:0]   win;
    logic              any_req;
    logic              full;
    logic              mem_req;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] va;
    logic [ADDR_W-1:0] pa;

    // Winner selection: locked channel in HOLD, else first requester at or after rr_ptr.
    always_comb begin : p_arb
        int unsigned idx;
        win     = rr_ptr_q;
        any_req = 1'b0;
        idx     = 0;
        if (state_q == HOLD) begin
            win     = gnt_q;
            any_req = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                idx = (32'(rr_ptr_q) + i) % NCH;
                if (!any_req && bus.ch_req[CH_W'(idx)]) begin
                    win     = CH_W'(idx);
                    any_req = 1'b1;
                end
            end
        end
    end

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign mem_req = resetn && any_req && !full;
    assign push    = mem_req && bus.mem_addr_ok;
    assign pop     = resetn && bus.mem_data_ok && (cnt_q != '0);

    // kseg0/kseg1 fold onto the low 512 MiB by clearing the top three address bits.
    always_comb begin
        va = bus.ch_addr[32'(win)*ADDR_W +: ADDR_W];
        pa = va;
        if (XLATE != 0 && va[ADDR_W-1 -: 2] == 2'b10) begin
            pa[ADDR_W-1 -: 3] = 3'b000;
        end
    end

    always_comb begin
        bus.mem_req    = mem_req;
        bus.mem_wr     = bus.ch_wr[win];
        bus.mem_size   = bus.ch_size[32'(win)*2 +: 2];
        bus.mem_addr   = pa;
        bus.mem_wdata  = bus.ch_wdata[32'(win)*DATA_W +: DATA_W];
        bus.ch_rdata   = bus.mem_rdata;
        bus.err        = err_q;
        bus.ch_addr_ok = '0;
        bus.ch_data_ok = '0;
        if (push) begin
            bus.ch_addr_ok[win] = 1'b1;
        end
        if (pop) begin
            bus.ch_data_ok[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        err_d    = err_q | (bus.mem_data_ok && (cnt_q == '0));

        case (state_q)
            IDLE: begin
                if (mem_req && !bus.mem_addr_ok) begin
                    state_d = HOLD;
                    gnt_d   = win;
                end
            end
            HOLD: begin
                if (push) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = win;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (32'(win) == NCH - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win + CH_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end
endmodule
